oled_pixel_streamer: RTL

Frame scanner and SPI serializer that sits between a pixel-generating renderer (such as the sorting-bar visualisers) and the PmodOLED pins. It walks every pixel of a 96x64 RGB565 frame in row-major order, presents the pixel index to the renderer, samples the returned colour and shifts it out MSB-first over SPI. It drives the same frame_begin / sending_pixels / sample_pixel / pixel_index handshake that renderers already consume, from the producer side. Panel power-up and command initialisation are outside this block.

---
 rtl/oled_pixel_streamer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer: walks a WIDTH x HEIGHT RGB565 frame in row-major order,
// fetches each pixel from the renderer and shifts it out MSB-first over SPI.
module oled_pixel_streamer #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned HEIGHT    = 64,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        sample_pixel,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        busy
);

  localparam int unsigned PIX_W = 13;
  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  typedef enum logic [2:0] {IDLE, START, FETCH, SHIFT, GAP} state_t;

  state_t           state;
  logic [14:0]      shift_q;   // bits still to send after the one on sdin
  logic [3:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // The panel is only ever fed pixel data by this block.
  assign d_cn = 1'b1;

  // Frame scanner / SPI serializer state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      shift_q        <= '0;
      bit_cnt        <= '0;
      div_cnt        <= '0;
      gap_cnt        <= '0;
      pixel_index    <= '0;
      frame_begin    <= 1'b0;
      sample_pixel   <= 1'b0;
      sending_pixels <= 1'b0;
      busy           <= 1'b0;
      cs             <= 1'b1;
      sclk           <= 1'b1;
      sdin           <= 1'b0;
    end else begin
      frame_begin  <= 1'b0;
      sample_pixel <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= START;
            frame_begin <= 1'b1;
            cs          <= 1'b0;
            busy        <= 1'b1;
            pixel_index <= '0;
          end
        end
        START: begin
          state          <= FETCH;
          sample_pixel   <= 1'b1;
          sending_pixels <= 1'b1;
        end
        FETCH: begin
          state   <= SHIFT;
          shift_q <= pixel_data[14:0];
          sdin    <= pixel_data[15];
          bit_cnt <= 4'd15;
          div_cnt <= '0;
          sclk    <= 1'b0;
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt != 4'd0) begin
              // Falling sclk: present the next bit for the following rise.
              bit_cnt <= bit_cnt - 4'd1;
              sclk    <= 1'b0;
              sdin    <= shift_q[14];
              shift_q <= {shift_q[13:0], 1'b0};
            end else if (pixel_index != LAST_PIX) begin
              state        <= FETCH;
              sample_pixel <= 1'b1;
              pixel_index  <= pixel_index + PIX_W'(1);
            end else begin
              state          <= GAP;
              pixel_index    <= '0;
              cs             <= 1'b1;
              sending_pixels <= 1'b0;
              gap_cnt        <= '0;
            end
          end
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end else if (enable) begin
            state       <= START;
            frame_begin <= 1'b1;
            cs          <= 1'b0;
            pixel_index <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
